// File: rtl/ltc2308_sampler.sv
// LTC2308 front end: runs back-to-back CONVST/SPI frames on one fixed channel,
// shifts in the 12-bit result, boxcar-averages 2^AVG_LOG2 results and presents
// a held code with a one-cycle valid strobe. The first frame after reset is
// dropped because the ADC's power-on configuration is unknown.
module ltc2308_sampler #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80,
    parameter int CHANNEL     = 0,
    parameter int AVG_LOG2    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        busy
);

    localparam int CW = $clog2(CONV_CYCLES + 1) + 1;
    localparam int DW = $clog2(CLK_DIV + 1) + 1;
    localparam int AW = 12 + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam logic [2:0]    CH       = 3'(CHANNEL);
    // S/D, O/S, S1, S0, UNI, SLP: single-ended, unipolar, no sleep
    localparam logic [5:0]    CFG_WORD = {1'b1, CH[0], CH[2], CH[1], 1'b1, 1'b0};
    localparam logic [NW-1:0] AVG_N    = NW'(1 << AVG_LOG2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV_START,
        S_WAIT_CONV,
        S_SHIFT,
        S_UPDATE
    } state_t;

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [DW-1:0]   r_div, w_div_next;
    logic [3:0]      r_bit, w_bit_next;
    logic            r_sck, w_sck_next;
    logic            r_convst, w_convst_next;
    logic [5:0]      r_cfg_sr, w_cfg_sr_next;
    logic [11:0]     r_shreg, w_shreg_next;
    logic [AW-1:0]   r_acc, w_acc_next;
    logic [NW-1:0]   r_count, w_count_next;
    logic            r_discard, w_discard_next;
    logic [11:0]     r_sample, w_sample_next;
    logic            r_valid, w_valid_next;
    logic            r_busy, w_busy_next;

    logic [AW-1:0]   w_acc_sum;
    logic [NW-1:0]   w_count_inc;

    assign w_acc_sum   = r_acc + AW'(r_shreg);
    assign w_count_inc = r_count + NW'(1);

    // Next-state and next-output decode; every output is registered so the
    // ADC pins and the display-stage inputs never see decode glitches.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_div_next     = r_div;
        w_bit_next     = r_bit;
        w_sck_next     = r_sck;
        w_cfg_sr_next  = r_cfg_sr;
        w_shreg_next   = r_shreg;
        w_acc_next     = r_acc;
        w_count_next   = r_count;
        w_discard_next = r_discard;
        w_sample_next  = r_sample;
        w_valid_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (enable) begin
                    w_state_next = S_CONV_START;
                end else begin
                    // a partial average is stale once the sampler stops
                    w_acc_next   = '0;
                    w_count_next = '0;
                end
            end
            S_CONV_START: begin
                if (r_cnt == CW'(1)) begin
                    w_state_next  = S_WAIT_CONV;
                    w_cnt_next    = '0;
                    w_cfg_sr_next = CFG_WORD;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_WAIT_CONV: begin
                if (r_cnt == CW'(CONV_CYCLES - 1)) begin
                    w_state_next = S_SHIFT;
                    w_cnt_next   = '0;
                    w_div_next   = '0;
                    w_bit_next   = '0;
                    w_sck_next   = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_SHIFT: begin
                if (r_div == DW'(CLK_DIV - 1)) begin
                    w_div_next = '0;
                    if (!r_sck) begin
                        // SCLK rising: capture the ADC bit
                        w_sck_next   = 1'b1;
                        w_shreg_next = {r_shreg[10:0], adc_sdo};
                    end else begin
                        // SCLK falling: present next config bit (zeros after 6)
                        w_sck_next    = 1'b0;
                        w_cfg_sr_next = {r_cfg_sr[4:0], 1'b0};
                        if (r_bit == 4'd11) begin
                            w_state_next = S_UPDATE;
                        end else begin
                            w_bit_next = r_bit + 4'd1;
                        end
                    end
                end else begin
                    w_div_next = r_div + DW'(1);
                end
            end
            S_UPDATE: begin
                w_cnt_next = '0;
                if (r_discard) begin
                    w_discard_next = 1'b0;
                end else if (w_count_inc == AVG_N) begin
                    w_sample_next = 12'(w_acc_sum >> AVG_LOG2);
                    w_valid_next  = 1'b1;
                    w_acc_next    = '0;
                    w_count_next  = '0;
                end else begin
                    w_acc_next   = w_acc_sum;
                    w_count_next = w_count_inc;
                end
                w_state_next = enable ? S_CONV_START : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_convst_next = (w_state_next == S_CONV_START);
        w_busy_next   = (w_state_next != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div     <= '0;
            r_bit     <= '0;
            r_sck     <= 1'b0;
            r_convst  <= 1'b0;
            r_cfg_sr  <= '0;
            r_shreg   <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_discard <= 1'b1;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_div     <= w_div_next;
            r_bit     <= w_bit_next;
            r_sck     <= w_sck_next;
            r_convst  <= w_convst_next;
            r_cfg_sr  <= w_cfg_sr_next;
            r_shreg   <= w_shreg_next;
            r_acc     <= w_acc_next;
            r_count   <= w_count_next;
            r_discard <= w_discard_next;
            r_sample  <= w_sample_next;
            r_valid   <= w_valid_next;
            r_busy    <= w_busy_next;
        end
    end

    assign adc_convst   = r_convst;
    assign adc_sck      = r_sck;
    assign adc_sdi      = r_cfg_sr[5];
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_ltc2308_sampler.sv
// Bench for ltc2308_sampler: two instances run in lockstep off one ADC model,
// one averaging 4 samples on channel 5, one pass-through on channel 0.
// Expected codes are queued per frame and popped on each valid strobe.
module tb_ltc2308_sampler;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic enable = 1'b0;
    logic sdo = 1'b0;

    logic        a_convst, a_sck, a_sdi, a_valid, a_busy;
    logic [11:0] a_sample;
    logic        p_convst, p_sck, p_sdi, p_valid, p_busy;
    logic [11:0] p_sample;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ltc2308_sampler #(.CLK_DIV(2), .CONV_CYCLES(80), .CHANNEL(5), .AVG_LOG2(2)) u_avg (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .adc_convst(a_convst), .adc_sck(a_sck), .adc_sdi(a_sdi), .adc_sdo(sdo),
        .sample(a_sample), .sample_valid(a_valid), .busy(a_busy)
    );

    ltc2308_sampler #(.CLK_DIV(2), .CONV_CYCLES(80), .CHANNEL(0), .AVG_LOG2(0)) u_pass (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .adc_convst(p_convst), .adc_sck(p_sck), .adc_sdi(p_sdi), .adc_sdo(sdo),
        .sample(p_sample), .sample_valid(p_valid), .busy(p_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // stimulus values, scoreboards, reference model of discard/averaging
    logic [11:0] vals[$];
    logic [11:0] q_avg[$];
    logic [11:0] q_pass[$];
    bit          m_discard = 1'b1;
    int          m_acc = 0;
    int          m_cnt = 0;

    int          cyc = 0;
    int          frames_started = 0;
    logic [11:0] cur_val = '0;
    int          bit_idx = 0;
    int          sck_cnt = 0;
    int          last_sck = 0;
    int          rise_cyc = 0;
    int          last_rise = 0;
    int          period = 0;
    int          convst_w = 0;
    logic [5:0]  a_cfg = '0, p_cfg = '0, last_a_cfg = '0, last_p_cfg = '0;

    always @(posedge clk) cyc++;

    always @(posedge a_convst) begin
        if (reset_n) begin
            last_sck  = sck_cnt;
            sck_cnt   = 0;
            period    = cyc - last_rise;
            last_rise = cyc;
            rise_cyc  = cyc;
        end
    end

    // frame start: ADC presents MSB, bench queues the expected outcome
    always @(negedge a_convst) begin
        if (reset_n) begin
            frames_started++;
            convst_w = cyc - rise_cyc;
            cur_val  = (vals.size() > 0) ? vals.pop_front() : 12'h000;
            bit_idx  = 11;
            sdo      = cur_val[11];
            if (m_discard) begin
                m_discard = 1'b0;
            end else begin
                q_pass.push_back(cur_val);
                m_acc += int'(cur_val);
                m_cnt++;
                if (m_cnt == 4) begin
                    q_avg.push_back(12'(m_acc / 4));
                    m_acc = 0;
                    m_cnt = 0;
                end
            end
        end
    end

    always @(negedge a_sck) begin
        if (reset_n && bit_idx > 0) begin
            bit_idx--;
            sdo = cur_val[bit_idx];
        end
    end

    always @(posedge a_sck) begin
        if (reset_n) begin
            sck_cnt++;
            if (sck_cnt <= 6) begin
                a_cfg = {a_cfg[4:0], a_sdi};
                p_cfg = {p_cfg[4:0], p_sdi};
            end
            if (sck_cnt == 6) begin
                last_a_cfg = a_cfg;
                last_p_cfg = p_cfg;
            end
        end
    end

    // strobe monitor: each valid pulse pops and compares one expected code
    always @(negedge clk) begin
        logic [11:0] e;
        if (reset_n) begin
            if (a_valid) begin
                if (q_avg.size() == 0) chk("avg_extra_strobe", a_valid, 0);
                else begin
                    e = q_avg.pop_front();
                    chk("avg_sample", a_sample, e);
                end
            end
            if (p_valid) begin
                if (q_pass.size() == 0) chk("pass_extra_strobe", p_valid, 0);
                else begin
                    e = q_pass.pop_front();
                    chk("pass_sample", p_sample, e);
                end
            end
        end
    end

    task automatic clear_model();
        m_discard = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        q_avg.delete();
        q_pass.delete();
        vals.delete();
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 5000 && frames_started < target; i++) @(negedge clk);
        chk("frames_reached", frames_started >= target, 1);
    endtask

    task automatic wait_sck(input int n);
        for (int i = 0; i < 2000 && sck_cnt < n; i++) @(negedge clk);
        chk("sck_edges_reached", sck_cnt >= n, 1);
    endtask

    task automatic stop_and_idle();
        enable = 1'b0;
        for (int i = 0; i < 1000 && a_busy; i++) @(negedge clk);
        chk("busy_fall", a_busy, 0);
        m_acc = 0;
        m_cnt = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic start_frames(input int n);
        int target;
        target = frames_started + n;
        enable = 1'b1;
        wait_frames(target);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        // reset and long idle
        #2 reset_n = 1'b0;
        clear_model();
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (500) @(negedge clk);
        chk("idle_convst", a_convst, 0);
        chk("idle_sck", a_sck, 0);
        chk("idle_sample", a_sample, 0);
        chk("idle_valid", a_valid, 0);
        chk("idle_busy", a_busy, 0);
        chk("idle_pass_sample", p_sample, 0);
        chk("idle_frames", frames_started, 0);

        // discard frame then four 0xA5C frames
        vals = '{12'h3C3, 12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C};
        start_frames(5);
        stop_and_idle();
        chk("convst_width", convst_w, 2);
        chk("sck_rises", last_sck, 12);
        chk("frame_period", period, 131);
        chk("cfg_ch5", last_a_cfg, 6'b111010);
        chk("cfg_ch0", last_p_cfg, 6'b100010);
        chk("hold_pass_a5c", p_sample, 12'hA5C);
        chk("hold_avg_a5c", a_sample, 12'hA5C);

        // averaging and full-scale, no discard on re-enable
        vals = '{12'd100, 12'd101, 12'd102, 12'd104, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        start_frames(8);
        stop_and_idle();
        chk("hold_avg_fff", a_sample, 12'hFFF);

        // enable drop mid-SHIFT with 2 of 4 accumulated
        vals = '{12'd7, 12'd9, 12'd11};
        start_frames(3);
        wait_sck(3);
        chk("busy_mid_shift", a_busy, 1);
        stop_and_idle();
        f = frames_started;
        repeat (200) @(negedge clk);
        chk("no_new_frame", frames_started, f);
        chk("hold_after_drop", a_sample, 12'hFFF);
        chk("pass_after_drop", p_sample, 12'd11);

        // fresh average after re-enable
        vals = '{12'd200, 12'd300, 12'd400, 12'd500};
        start_frames(4);
        stop_and_idle();
        chk("avg_350_held", a_sample, 12'd350);

        // async reset mid-SHIFT at the 7th SCLK edge, between clk edges
        vals = '{12'h555};
        start_frames(1);
        wait_sck(7);
        chk("busy_before_rst", a_busy, 1);
        chk("sck_before_rst", a_sck, 1);
        #2;
        reset_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("rst_convst", a_convst, 0);
        chk("rst_sck", a_sck, 0);
        chk("rst_sdi", a_sdi, 0);
        chk("rst_sample", a_sample, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_pass_sample", p_sample, 0);
        clear_model();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // first frame after release is discarded again
        vals = '{12'h111, 12'h222};
        start_frames(2);
        stop_and_idle();
        chk("pass_after_rst", p_sample, 12'h222);
        chk("avg_after_rst", a_sample, 0);

        chk("q_avg_empty", q_avg.size(), 0);
        chk("q_pass_empty", q_pass.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
